rf_wb_buffer: RTL and testbench

RF_WB_BUFFER -- requirements
Module: rf_wb_buffer

---
 rtl/rf_wb_buffer_if.sv | 28 ++
 rtl/rf_wb_buffer.sv | 108 ++++++++++
 tb/tb_rf_wb_buffer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_buffer_if.sv
// Bundles the result-input, register-file write and forwarding signals of the
// write-back buffer; the slave modport is the buffer's view of the bus.
interface rf_wb_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                 in_valid_i;
    logic [1:0][4:0]            in_addr_i;
    logic [1:0][DATA_WIDTH-1:0] in_data_i;
    logic                       in_ready_o;
    logic                       wb_hold_i;
    logic [1:0]                 w_en_o;
    logic [1:0][4:0]            w_addr_o;
    logic [1:0][DATA_WIDTH-1:0] w_data_o;
    logic [3:0][4:0]            r_addr_i;
    logic [3:0]                 fwd_hit_o;
    logic [3:0][DATA_WIDTH-1:0] fwd_data_o;
    logic                       empty_o;

    modport slave (
        input  in_valid_i, in_addr_i, in_data_i, wb_hold_i, r_addr_i,
        output in_ready_o, w_en_o, w_addr_o, w_data_o, fwd_hit_o, fwd_data_o, empty_o
    );

    modport master (
        output in_valid_i, in_addr_i, in_data_i, wb_hold_i, r_addr_i,
        input  in_ready_o, w_en_o, w_addr_o, w_data_o, fwd_hit_o, fwd_data_o, empty_o
    );
endinterface

// File: rtl/rf_wb_buffer.sv
// Two-wide write-back FIFO in front of a 4R2W register file: absorbs result
// pairs, drains up to two entries per cycle and forwards pending values to readers.
module rf_wb_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic           clk,
    input logic           rst,
    rf_wb_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [4:0]            addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

    logic                  ready_s;
    logic                  acc0_s, acc1_s;
    logic [PW-1:0]         slot1_idx_s;
    logic [PW-1:0]         head1_idx_s;
    logic [CW-1:0]         push_cnt_s;
    logic [CW-1:0]         pop_cnt_s;
    logic [1:0]            w_en_s;
    logic [3:0]            fwd_hit_s;
    logic [3:0][DATA_WIDTH-1:0] fwd_data_s;

    // Enqueue qualification and pointer/count next-state.
    always_comb begin
        ready_s     = (count_q <= CW'(DEPTH - 2));
        acc0_s      = ready_s && bus.in_valid_i[0] && (bus.in_addr_i[0] != 5'd0);
        acc1_s      = ready_s && bus.in_valid_i[1] && (bus.in_addr_i[1] != 5'd0);
        slot1_idx_s = acc0_s ? (tail_q + PW'(1)) : tail_q;
        push_cnt_s  = CW'(acc0_s) + CW'(acc1_s);
        if (bus.wb_hold_i) begin
            pop_cnt_s = CW'(0);
        end else if (count_q >= CW'(2)) begin
            pop_cnt_s = CW'(2);
        end else begin
            pop_cnt_s = count_q;
        end
        head_d  = head_q + pop_cnt_s[PW-1:0];
        tail_d  = tail_q + push_cnt_s[PW-1:0];
        count_d = count_q - pop_cnt_s + push_cnt_s;
    end

    // Drain ports; a duplicate address in a popped pair leaves only the younger write.
    always_comb begin
        head1_idx_s = head_q + PW'(1);
        w_en_s[1]   = (pop_cnt_s == CW'(2));
        w_en_s[0]   = (pop_cnt_s != CW'(0)) &&
                      !(w_en_s[1] && (addr_mem_q[head_q] == addr_mem_q[head1_idx_s]));
    end

    // Forwarding scans oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit_s  = 4'b0000;
        fwd_data_s = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_q) && (bus.r_addr_i[k] != 5'd0) &&
                    (addr_mem_q[head_q + PW'(i)] == bus.r_addr_i[k])) begin
                    fwd_hit_s[k]  = 1'b1;
                    fwd_data_s[k] = data_mem_q[head_q + PW'(i)];
                end else begin
                    fwd_data_s[k] = fwd_data_s[k];
                end
            end
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; validity is tracked by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (acc0_s) begin
            addr_mem_q[tail_q] <= bus.in_addr_i[0];
            data_mem_q[tail_q] <= bus.in_data_i[0];
        end
        if (acc1_s) begin
            addr_mem_q[slot1_idx_s] <= bus.in_addr_i[1];
            data_mem_q[slot1_idx_s] <= bus.in_data_i[1];
        end
    end

    assign bus.in_ready_o  = ready_s;
    assign bus.empty_o     = (count_q == CW'(0));
    assign bus.w_en_o      = w_en_s;
    assign bus.w_addr_o[0] = addr_mem_q[head_q];
    assign bus.w_addr_o[1] = addr_mem_q[head1_idx_s];
    assign bus.w_data_o[0] = data_mem_q[head_q];
    assign bus.w_data_o[1] = data_mem_q[head1_idx_s];
    assign bus.fwd_hit_o   = fwd_hit_s;
    assign bus.fwd_data_o  = fwd_data_s;
endmodule

// File: tb/tb_rf_wb_buffer.sv
// Directed self-checking bench for rf_wb_buffer (DATA_WIDTH=32, DEPTH=4).
module tb_rf_wb_buffer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rf_wb_buffer_if #(.DATA_WIDTH(32)) bus ();

    rf_wb_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
        bus.in_valid_i   = v;
        bus.in_addr_i[0] = a0;
        bus.in_addr_i[1] = a1;
        bus.in_data_i[0] = d0;
        bus.in_data_i[1] = d1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.wb_hold_i = 1'b0;
        bus.r_addr_i  = '0;
        set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.in_ready_o, 1'b1);
        chk("rst_wen",   bus.w_en_o,     2'b00);
        chk("rst_hit",   bus.fwd_hit_o,  4'b0000);
        chk("rst_empty", bus.empty_o,    1'b1);
        rst = 1'b0;

        // Basic pair: written the cycle after acceptance, then empty
        set_in(2'b11, 5'd3, 5'd5, 32'hAAAA_0001, 32'hBBBB_0002);
        tick();
        set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        bus.r_addr_i[1] = 5'd5;
        #1;
        chk("pair_wen",   bus.w_en_o,      2'b11);
        chk("pair_a0",    bus.w_addr_o[0], 5'd3);
        chk("pair_a1",    bus.w_addr_o[1], 5'd5);
        chk("pair_d0",    bus.w_data_o[0], 32'hAAAA_0001);
        chk("pair_d1",    bus.w_data_o[1], 32'hBBBB_0002);
        chk("pair_fhit",  bus.fwd_hit_o[1], 1'b1);
        chk("pair_fdat",  bus.fwd_data_o[1], 32'hBBBB_0002);
        chk("pair_nempty", bus.empty_o,    1'b0);
        tick();
        chk("pair_empty", bus.empty_o,  1'b1);
        chk("pair_idle",  bus.w_en_o,   2'b00);
        bus.r_addr_i = '0;

        // Same-address pair: only the younger port writes
        set_in(2'b11, 5'd7, 5'd7, 32'h1, 32'h2);
        tick();
        set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        chk("dup_wen0", bus.w_en_o[0],   1'b0);
        chk("dup_wen1", bus.w_en_o[1],   1'b1);
        chk("dup_a1",   bus.w_addr_o[1], 5'd7);
        chk("dup_d1",   bus.w_data_o[1], 32'h2);
        tick();
        chk("dup_empty", bus.empty_o, 1'b1);

        // Address-0 slot discarded: single r9 entry on port 0
        set_in(2'b11, 5'd0, 5'd9, 32'h5, 32'h6);
        tick();
        set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        chk("z_wen", bus.w_en_o,      2'b01);
        chk("z_a0",  bus.w_addr_o[0], 5'd9);
        chk("z_d0",  bus.w_data_o[0], 32'h6);
        tick();
        chk("z_empty", bus.empty_o, 1'b1);

        // Hold: fill to 4 entries, third pair ignored, drain across wrap
        bus.wb_hold_i = 1'b1;
        set_in(2'b11, 5'd1, 5'd2, 32'h11, 32'h12);
        tick();
        chk("h1_ready", bus.in_ready_o, 1'b1);
        chk("h1_wen",   bus.w_en_o,     2'b00);
        set_in(2'b11, 5'd3, 5'd4, 32'h13, 32'h14);
        tick();
        chk("h2_ready", bus.in_ready_o, 1'b0);
        set_in(2'b11, 5'd5, 5'd6, 32'h15, 32'h16);
        tick();
        chk("h3_ready", bus.in_ready_o, 1'b0);
        set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        bus.wb_hold_i = 1'b0;
        #1;
        chk("d1_wen", bus.w_en_o,      2'b11);
        chk("d1_a0",  bus.w_addr_o[0], 5'd1);
        chk("d1_a1",  bus.w_addr_o[1], 5'd2);
        chk("d1_d1",  bus.w_data_o[1], 32'h12);
        tick();
        chk("d2_wen", bus.w_en_o,      2'b11);
        chk("d2_a0",  bus.w_addr_o[0], 5'd3);
        chk("d2_a1",  bus.w_addr_o[1], 5'd4);
        chk("d2_d0",  bus.w_data_o[0], 32'h13);
        tick();
        chk("d3_empty", bus.empty_o,    1'b1);
        chk("d3_wen",   bus.w_en_o,     2'b00);
        chk("d3_ready", bus.in_ready_o, 1'b1);

        // Forwarding: youngest match, address 0 never hits, same-cycle inputs not forwarded
        bus.wb_hold_i = 1'b1;
        set_in(2'b11, 5'd4, 5'd4, 32'h111, 32'h222);
        tick();
        set_in(2'b11, 5'd8, 5'd8, 32'h333, 32'h444);
        bus.r_addr_i[0] = 5'd0;
        bus.r_addr_i[1] = 5'd9;
        bus.r_addr_i[2] = 5'd4;
        bus.r_addr_i[3] = 5'd8;
        #1;
        chk("f_hit2",  bus.fwd_hit_o[2],  1'b1);
        chk("f_dat2",  bus.fwd_data_o[2], 32'h222);
        chk("f_hit0",  bus.fwd_hit_o[0],  1'b0);
        chk("f_hit1",  bus.fwd_hit_o[1],  1'b0);
        chk("f_same",  bus.fwd_hit_o[3],  1'b0);
        tick();
        set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        chk("f_hit3", bus.fwd_hit_o[3],  1'b1);
        chk("f_dat3", bus.fwd_data_o[3], 32'h444);
        bus.wb_hold_i = 1'b0;
        #1;
        chk("f_pop_hit", bus.fwd_hit_o[2], 1'b1);
        chk("f_dr_wen",  bus.w_en_o,       2'b10);
        chk("f_dr_d1",   bus.w_data_o[1],  32'h222);
        tick();
        chk("f_dr2_wen", bus.w_en_o,       2'b10);
        chk("f_dr2_a1",  bus.w_addr_o[1],  5'd8);
        tick();
        chk("f_dr_empty", bus.empty_o, 1'b1);
        bus.r_addr_i = '0;

        // Asynchronous reset with three entries buffered
        bus.wb_hold_i = 1'b1;
        set_in(2'b11, 5'd10, 5'd11, 32'h21, 32'h22);
        tick();
        set_in(2'b11, 5'd12, 5'd0, 32'h23, 32'h24);
        tick();
        set_in(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        chk("r_ready3", bus.in_ready_o, 1'b0);
        bus.wb_hold_i = 1'b0;
        #1;
        chk("r_pre_wen", bus.w_en_o, 2'b11);
        rst = 1'b1;
        #1;
        chk("r_wen",   bus.w_en_o,     2'b00);
        chk("r_empty", bus.empty_o,    1'b1);
        chk("r_ready", bus.in_ready_o, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk("r_post_wen",   bus.w_en_o,  2'b00);
        chk("r_post_empty", bus.empty_o, 1'b1);
        tick();
        chk("r_post2_wen", bus.w_en_o, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
